// File: rtl/mem_latency_model_if.sv
// Request/response bus between a requester (master) and the mem_latency_model backing store (slave).
interface mem_latency_model_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NB-1:0]     req_be;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_we;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_we, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_we, resp_err
    );
endinterface

// File: rtl/mem_latency_model.sv
// Word-wide byte-addressable memory with fixed latency, in-order responses and response backpressure.
// Optional macro MEM_MISALIGN_ERR_EN: flag misaligned accesses with resp_err and suppress their effect.
module mem_latency_model #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 4
) (
    input  logic                clk,
    input  logic                resetN,
    mem_latency_model_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);

    typedef struct packed {
        logic              we;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [7:0]        mem [DEPTH];
    logic              rst_done;
    logic [CNT_W-1:0]  inflight;
    logic              acc;
    logic              cpl;
    logic [ADDR_W-1:0] ea;
    logic              misal;
    rsp_t              acc_rsp;
    logic              pipe_out_vld;
    rsp_t              pipe_out;
    rsp_t              fifo [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fcnt;
    rsp_t              head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready is held low for the first cycle after reset release.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rst_done <= 1'b0;
        else         rst_done <= 1'b1;
    end

    assign bus.req_ready = rst_done && (inflight < CNT_W'(MAX_OUT));
    assign acc           = bus.req_valid && bus.req_ready;
    assign cpl           = bus.resp_valid && bus.resp_ready;
    assign ea            = bus.req_addr & ~LANE_MASK;

`ifdef MEM_MISALIGN_ERR_EN
    assign misal = (bus.req_addr & LANE_MASK) != '0;
`else
    logic unused_lane_bits;
    assign misal            = 1'b0;
    assign unused_lane_bits = ^(bus.req_addr & LANE_MASK);
`endif

    always_comb begin
        acc_rsp      = '0;
        acc_rsp.we   = bus.req_we;
        acc_rsp.err  = misal;
        if (!bus.req_we && !misal) begin
            for (int i = 0; i < NB; i++) begin
                acc_rsp.data[8*i +: 8] = mem[ea | ADDR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[ADDR_W'(a)] <= '0;
            end
        end else if (acc && bus.req_we && !misal) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_be[i]) mem[ea | ADDR_W'(i)] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    // The final pipeline stage is the FIFO write itself, so LATENCY-1 registers sit in front of it.
    if (LATENCY > 1) begin : g_pipe
        logic [LATENCY-2:0] vld;
        rsp_t               stg [LATENCY-1];

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                vld <= '0;
                for (int k = 0; k < LATENCY - 1; k++) begin
                    stg[k] <= '0;
                end
            end else begin
                vld[0] <= acc;
                stg[0] <= acc_rsp;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    vld[k] <= vld[k-1];
                    stg[k] <= stg[k-1];
                end
            end
        end

        assign pipe_out_vld = vld[LATENCY-2];
        assign pipe_out     = stg[LATENCY-2];
    end else begin : g_direct
        assign pipe_out_vld = acc;
        assign pipe_out     = acc_rsp;
    end

    // inflight bounds pipeline plus FIFO occupancy, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + CNT_W'(acc) - CNT_W'(cpl);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            for (int j = 0; j < MAX_OUT; j++) begin
                fifo[j] <= '0;
            end
        end else begin
            if (pipe_out_vld) begin
                fifo[wr_ptr] <= pipe_out;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (cpl) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fcnt <= fcnt + CNT_W'(pipe_out_vld) - CNT_W'(cpl);
        end
    end

    assign head           = fifo[rd_ptr];
    assign bus.resp_valid = (fcnt != '0);
    assign bus.resp_rdata = bus.resp_valid ? head.data : '0;
    assign bus.resp_we    = bus.resp_valid ? head.we   : 1'b0;
    assign bus.resp_err   = bus.resp_valid ? head.err  : 1'b0;
endmodule

// File: tb/tb_mem_latency_model.sv
// Scoreboard bench for mem_latency_model: expectations come from a byte-array reference model.
// Honours MEM_MISALIGN_ERR_EN the same way the design does.
module tb_mem_latency_model;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 2;
    localparam int MAX_OUT = 4;
    localparam int NB      = DATA_W / 8;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    mem_latency_model_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_latency_model #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LATENCY(LATENCY),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    typedef struct {
        logic              we;
        logic              err;
        logic [DATA_W-1:0] data;
        int                cyc;
        bit                chk_lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_mem [DEPTH];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void clear_model();
        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
    endfunction

    // Called in the cycle a request is seen accepted; builds the expected response.
    function automatic void record_accept(input logic we, input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] wd, input logic [NB-1:0] be,
                                          input bit chk);
        exp_t e;
        logic mis;
        int   ea;
        mis = 1'b0;
`ifdef MEM_MISALIGN_ERR_EN
        mis = (addr[1:0] != 2'b00);
`endif
        ea        = int'(addr) & ~(NB - 1);
        e.we      = we;
        e.err     = mis;
        e.data    = '0;
        e.cyc     = cyc + LATENCY;
        e.chk_lat = chk;
        if (we) begin
            if (!mis) begin
                for (int i = 0; i < NB; i++) if (be[i]) model_mem[ea + i] = wd[8*i +: 8];
            end
        end else if (!mis) begin
            for (int i = 0; i < NB; i++) e.data[8*i +: 8] = model_mem[ea + i];
        end
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (resetN === 1'b1 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("resp_rdata", bus.resp_rdata, e.data);
                check_val("resp_we", bus.resp_we, e.we);
                check_val("resp_err", bus.resp_err, e.err);
                if (e.chk_lat) check_val("resp_latency", cyc, e.cyc);
            end
        end
    end

    // Call just after a rising edge; returns just after the rising edge that accepted the request.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input logic [NB-1:0] be, input bit chk);
        bit done;
        done          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_be    = be;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                record_accept(we, addr, wd, be, chk);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!done) check_val("req_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60 && (sb.size() != 0 || bus.resp_valid); t++) begin
            @(posedge clk);
            #1;
        end
        check_val("drain_empty", sb.size(), 64'd0);
    endtask

    initial begin
        int                acc_n;
        logic [DATA_W-1:0] snap_d;
        logic              snap_we;
        logic              snap_err;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_be     = '0;
        bus.resp_ready = 1'b1;
        clear_model();

        #2;
        check_val("rst_resp_valid", bus.resp_valid, 64'd0);
        check_val("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check_val("rst_resp_we", bus.resp_we, 64'd0);
        check_val("rst_resp_err", bus.resp_err, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 resetN = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_req_ready", bus.req_ready, 64'd1);

        // Reset with traffic in flight.
        do_req(1'b1, 11'h040, 32'hCAFEF00D, 4'hF, 1'b1);
        do_req(1'b0, 11'h040, '0, '0, 1'b1);
        do_req(1'b0, 11'h044, '0, '0, 1'b1);
        #3 resetN = 1'b0;
        sb.delete();
        clear_model();
        #1;
        check_val("midrst_resp_valid", bus.resp_valid, 64'd0);
        check_val("midrst_resp_rdata", bus.resp_rdata, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 resetN = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_req_ready", bus.req_ready, 64'd1);
        do_req(1'b0, 11'h040, '0, '0, 1'b1);
        wait_drain();

        // Full store then load; partial store then load.
        do_req(1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 1'b1);
        do_req(1'b0, 11'h010, '0, '0, 1'b1);
        do_req(1'b1, 11'h010, 32'h11223344, 4'b0101, 1'b1);
        do_req(1'b0, 11'h010, '0, '0, 1'b1);
        wait_drain();

        // Distinct patterns, then 8 back-to-back loads.
        for (int i = 0; i < 8; i++)
            do_req(1'b1, ADDR_W'(i * 4), {8'(i + 8'h10), 8'(i + 8'h20), 8'(i + 8'h30), 8'(i + 8'h40)},
                   4'hF, 1'b0);
        wait_drain();
        for (int i = 0; i < 8; i++) do_req(1'b0, ADDR_W'(i * 4), '0, '0, 1'b1);
        wait_drain();

        // Backpressure: fill until req_ready drops, hold, then release.
        bus.resp_ready = 1'b0;
        acc_n          = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                record_accept(1'b0, bus.req_addr, '0, '0, 1'b0);
                acc_n++;
            end
            @(posedge clk);
            #1 bus.req_addr = ADDR_W'(acc_n * 4);
        end
        bus.req_valid = 1'b0;
        check_val("bp_accepted", acc_n, MAX_OUT);
        @(negedge clk);
        check_val("bp_valid", bus.resp_valid, 64'd1);
        check_val("bp_head", bus.resp_rdata, sb[0].data);
        snap_d   = bus.resp_rdata;
        snap_we  = bus.resp_we;
        snap_err = bus.resp_err;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check_val("bp_hold_valid", bus.resp_valid, 64'd1);
            check_val("bp_hold_rdata", bus.resp_rdata, snap_d);
            check_val("bp_hold_we", bus.resp_we, snap_we);
            check_val("bp_hold_err", bus.resp_err, snap_err);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        wait_drain();

        // Misaligned store, then aligned read-back of the same word.
        do_req(1'b1, 11'h013, 32'hFFFFFFFF, 4'hF, 1'b1);
        do_req(1'b0, 11'h010, '0, '0, 1'b1);
        wait_drain();

        // Top word of the address space.
        do_req(1'b1, 11'h7FC, 32'hA5A55A5A, 4'hF, 1'b1);
        do_req(1'b0, 11'h7FC, '0, '0, 1'b1);
        do_req(1'b0, 11'h7FE, '0, '0, 1'b1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
